alu_input: RTL and testbench

Operand-capture and issue stage for the ALU: the receive side of the MainBus path that ALU_Output drives. It latches LHS and RHS bytes from MainBus on load strobes. When an operation request arrives and both operands are present, it resolves carry-in from the previous-result flags and issues one registered operation to the shift/logic units over a valid/ready handshake.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_input_if.sv | 46 ++++
 rtl/alu_operand_reg.sv | 68 ++++++
 rtl/alu_input.sv | 103 ++++++++++
 tb/tb_alu_input.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU operand-capture / issue
//                stage: default bus and opcode widths, carry-select codes,
//                the operand-state encoding and the carry-in resolver.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int c_data_w_dflt = 8;
    localparam int c_op_w_dflt   = 4;

    // Carry-select codes, indexed by {AC7_CS1, AC6_CS0}
    localparam logic [1:0] CS_ZERO   = 2'd0;
    localparam logic [1:0] CS_CARRYA = 2'd1;
    localparam logic [1:0] CS_CARRYL = 2'd2;
    localparam logic [1:0] CS_ONE    = 2'd3;

    // Operand state, encoded as {LHS available, RHS available}
    typedef enum logic [1:0] {
        OPND_EMPTY    = 2'b00,
        OPND_RHS_ONLY = 2'b01,
        OPND_LHS_ONLY = 2'b10,
        OPND_FULL     = 2'b11
    } opnd_state_e;

    function automatic logic carry_sel(input logic [1:0] cs,
                                       input logic       carry_a,
                                       input logic       carry_l);
        logic w_c;
        w_c = 1'b0;
        case (cs)
            CS_ZERO:   w_c = 1'b0;
            CS_CARRYA: w_c = carry_a;
            CS_CARRYL: w_c = carry_l;
            CS_ONE:    w_c = 1'b1;
            default:   w_c = 1'b0;
        endcase
        return w_c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_input_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_if
//  Description : MainBus receive / execute-issue bundle for alu_input.
//                slave  : view of the issue stage (alu_input)
//                master : view of the bus driver / requester / execute unit
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_input_if
    import alu_pkg::*;
#(
    parameter int DATA_W = c_data_w_dflt,
    parameter int OP_W   = c_op_w_dflt
) ();

    logic [DATA_W-1:0] MainBus;
    logic              Load_LHS;
    logic              Load_RHS;
    logic              Op_Valid;
    logic [OP_W-1:0]   Op_Code;
    logic              AC6_CS0;
    logic              AC7_CS1;
    logic              Flags_3_CarryA;
    logic              Flags_4_CarryL;
    logic              Op_Ready;
    logic              Exec_Valid;
    logic              Exec_Ready;
    logic [DATA_W-1:0] Exec_LHS;
    logic [DATA_W-1:0] Exec_RHS;
    logic [OP_W-1:0]   Exec_Op;
    logic              Exec_CarryIn;

    modport slave (
        input  MainBus, Load_LHS, Load_RHS, Op_Valid, Op_Code,
               AC6_CS0, AC7_CS1, Flags_3_CarryA, Flags_4_CarryL, Exec_Ready,
        output Op_Ready, Exec_Valid, Exec_LHS, Exec_RHS, Exec_Op, Exec_CarryIn
    );

    modport master (
        output MainBus, Load_LHS, Load_RHS, Op_Valid, Op_Code,
               AC6_CS0, AC7_CS1, Flags_3_CarryA, Flags_4_CarryL, Exec_Ready,
        input  Op_Ready, Exec_Valid, Exec_LHS, Exec_RHS, Exec_Op, Exec_CarryIn
    );

endinterface
`default_nettype wire

// File: rtl/alu_operand_reg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_reg
//  Description : One operand slot: data register, valid bit and (optional)
//                bus bypass. Used once for LHS and once for RHS.
//  Ports       : clk, rst     clock, synchronous active-high reset
//                i_load       capture i_bus this cycle
//                i_bus        MainBus value
//                i_consume    operation accepted this cycle
//                o_value      operand value presented to the issue mux
//                o_avail      operand is usable this cycle
//  Macro       : ALU_INPUT_BYPASS_EN - a load is usable in its own cycle and
//                is consumed by a same-cycle accept.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_reg #(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [DATA_W-1:0] i_bus,
    input  wire logic              i_consume,
    output logic      [DATA_W-1:0] o_value,
    output logic                   o_avail
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_load) begin
                r_data <= i_bus;
            end
`ifdef ALU_INPUT_BYPASS_EN
            // A same-cycle load was already forwarded to the accept, so the
            // consume takes precedence and the slot empties.
            if (i_consume) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end
`else
            // The accept used the old value; a same-cycle load is a fresh
            // operand for the next operation.
            if (i_load) begin
                r_valid <= 1'b1;
            end else if (i_consume) begin
                r_valid <= 1'b0;
            end
`endif
        end
    end

`ifdef ALU_INPUT_BYPASS_EN
    assign o_avail = r_valid | i_load;
    assign o_value = i_load ? i_bus : r_data;
`else
    assign o_avail = r_valid;
    assign o_value = r_data;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_input.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input
//  Description : ALU operand-capture and issue stage. Latches LHS/RHS from
//                MainBus on load strobes, and when an operation request
//                arrives with both operands present, issues one registered
//                operation (operands, opcode, resolved carry-in) to execute
//                over a valid/ready handshake.
//  Ports       : AluClock     clock
//                Reset        synchronous active-high reset
//                bus          alu_input_if.slave (MainBus, loads, request,
//                             carry select/flags, execute handshake/outputs)
//  Macro       : ALU_INPUT_BYPASS_EN - forward MainBus straight into the
//                issue register on a same-cycle load; 1-cycle cadence.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_input
    import alu_pkg::*;
#(
    parameter int DATA_W = c_data_w_dflt,
    parameter int OP_W   = c_op_w_dflt
) (
    input wire logic    AluClock,
    input wire logic    Reset,
    alu_input_if.slave  bus
);

    logic [DATA_W-1:0] w_lhs_value;
    logic [DATA_W-1:0] w_rhs_value;
    logic              w_lhs_avail;
    logic              w_rhs_avail;
    opnd_state_e       w_opnd_state;
    logic              w_slot_free;
    logic              w_op_ready;
    logic              w_accept;
    logic              w_carry_in;

    logic              r_exec_valid;
    logic [DATA_W-1:0] r_exec_lhs;
    logic [DATA_W-1:0] r_exec_rhs;
    logic [OP_W-1:0]   r_exec_op;
    logic              r_exec_carry;

    alu_operand_reg #(.DATA_W(DATA_W)) u_lhs (
        .clk       (AluClock),
        .rst       (Reset),
        .i_load    (bus.Load_LHS),
        .i_bus     (bus.MainBus),
        .i_consume (w_accept),
        .o_value   (w_lhs_value),
        .o_avail   (w_lhs_avail)
    );

    alu_operand_reg #(.DATA_W(DATA_W)) u_rhs (
        .clk       (AluClock),
        .rst       (Reset),
        .i_load    (bus.Load_RHS),
        .i_bus     (bus.MainBus),
        .i_consume (w_accept),
        .o_value   (w_rhs_value),
        .o_avail   (w_rhs_avail)
    );

    assign w_opnd_state = opnd_state_e'({w_lhs_avail, w_rhs_avail});

    // The slot is free when empty or being drained this cycle, which allows
    // back-to-back replacement without a bubble.
    assign w_slot_free = ~r_exec_valid | bus.Exec_Ready;

    // Reset wins over everything, so no request is advertised during it.
    assign w_op_ready  = (w_opnd_state == OPND_FULL) & w_slot_free & ~Reset;
    assign w_accept    = bus.Op_Valid & w_op_ready;

    assign w_carry_in  = carry_sel({bus.AC7_CS1, bus.AC6_CS0},
                                   bus.Flags_3_CarryA, bus.Flags_4_CarryL);

    always_ff @(posedge AluClock) begin
        if (Reset) begin
            r_exec_valid <= 1'b0;
            r_exec_lhs   <= '0;
            r_exec_rhs   <= '0;
            r_exec_op    <= '0;
            r_exec_carry <= 1'b0;
        end else if (w_accept) begin
            r_exec_valid <= 1'b1;
            r_exec_lhs   <= w_lhs_value;
            r_exec_rhs   <= w_rhs_value;
            r_exec_op    <= bus.Op_Code;
            r_exec_carry <= w_carry_in;
        end else if (bus.Exec_Ready) begin
            r_exec_valid <= 1'b0;
        end
    end

    assign bus.Op_Ready     = w_op_ready;
    assign bus.Exec_Valid   = r_exec_valid;
    assign bus.Exec_LHS     = r_exec_lhs;
    assign bus.Exec_RHS     = r_exec_rhs;
    assign bus.Exec_Op      = r_exec_op;
    assign bus.Exec_CarryIn = r_exec_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_input
//  Description : Self-checking bench for alu_input: directed scenarios with
//                literal expectations plus randomized traffic checked every
//                cycle against a behavioural operand/issue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_input;

`ifdef ALU_INPUT_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_input_if bus ();

    alu_input dut (
        .AluClock (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model state
    bit         m_known = 1'b0;
    logic [7:0] m_lhs = '0, m_rhs = '0;
    bit         m_lv = 1'b0, m_rv = 1'b0;
    bit         m_ev = 1'b0;
    logic [7:0] m_el = '0, m_er = '0;
    logic [3:0] m_eo = '0;
    bit         m_ec = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bit exp_ready();
        bit la, ra;
        la = m_lv || (c_bypass && bus.Load_LHS);
        ra = m_rv || (c_bypass && bus.Load_RHS);
        return !rst && la && ra && (!m_ev || bus.Exec_Ready);
    endfunction

    task automatic compare_all();
        if (m_known) begin
            chk("op_ready", 32'(bus.Op_Ready), 32'(exp_ready()));
            chk("exec_valid", 32'(bus.Exec_Valid), 32'(m_ev));
            if (m_ev) begin
                chk("exec_lhs", 32'(bus.Exec_LHS), 32'(m_el));
                chk("exec_rhs", 32'(bus.Exec_RHS), 32'(m_er));
                chk("exec_op", 32'(bus.Exec_Op), 32'(m_eo));
                chk("exec_carry", 32'(bus.Exec_CarryIn), 32'(m_ec));
            end
        end
    endtask

    task automatic model_update();
        bit         acc;
        logic [7:0] vl, vr;
        bit         cin;
        logic [1:0] cs;
        if (rst) begin
            m_known = 1'b1;
            m_lhs = '0; m_rhs = '0; m_lv = 0; m_rv = 0;
            m_ev = 0; m_el = '0; m_er = '0; m_eo = '0; m_ec = 0;
        end else begin
            acc = bus.Op_Valid && exp_ready();
            vl  = (c_bypass && bus.Load_LHS) ? bus.MainBus : m_lhs;
            vr  = (c_bypass && bus.Load_RHS) ? bus.MainBus : m_rhs;
            cs  = {bus.AC7_CS1, bus.AC6_CS0};
            cin = (cs == 2'd0) ? 1'b0 :
                  (cs == 2'd1) ? bus.Flags_3_CarryA :
                  (cs == 2'd2) ? bus.Flags_4_CarryL : 1'b1;
            if (acc) begin
                m_ev = 1; m_el = vl; m_er = vr; m_eo = bus.Op_Code; m_ec = cin;
            end else if (bus.Exec_Ready) begin
                m_ev = 0;
            end
            if (bus.Load_LHS) m_lhs = bus.MainBus;
            if (bus.Load_RHS) m_rhs = bus.MainBus;
            if (c_bypass) begin
                m_lv = acc ? 1'b0 : (bus.Load_LHS ? 1'b1 : m_lv);
                m_rv = acc ? 1'b0 : (bus.Load_RHS ? 1'b1 : m_rv);
            end else begin
                m_lv = bus.Load_LHS ? 1'b1 : (acc ? 1'b0 : m_lv);
                m_rv = bus.Load_RHS ? 1'b1 : (acc ? 1'b0 : m_rv);
            end
        end
    endtask

    // One clock cycle: drive on the falling edge, check, then advance model.
    task automatic cyc(input bit r, input bit ll, input bit lr,
                       input logic [7:0] d, input bit ov, input logic [3:0] op,
                       input logic [1:0] cs, input bit fa, input bit fl,
                       input bit er);
        @(negedge clk);
        rst                = r;
        bus.Load_LHS       = ll;
        bus.Load_RHS       = lr;
        bus.MainBus        = d;
        bus.Op_Valid       = ov;
        bus.Op_Code        = op;
        bus.AC6_CS0        = cs[0];
        bus.AC7_CS1        = cs[1];
        bus.Flags_3_CarryA = fa;
        bus.Flags_4_CarryL = fl;
        bus.Exec_Ready     = er;
        #1 compare_all();
        @(posedge clk);
        model_update();
    endtask

    // Shorthands: load LHS / RHS / both, request, idle
    task automatic ld_l(input logic [7:0] d, input bit er);
        cyc(0, 1, 0, d, 0, 4'h0, 2'd0, 0, 0, er);
    endtask
    task automatic ld_r(input logic [7:0] d, input bit er);
        cyc(0, 0, 1, d, 0, 4'h0, 2'd0, 0, 0, er);
    endtask
    task automatic ld_b(input logic [7:0] d, input bit er);
        cyc(0, 1, 1, d, 0, 4'h0, 2'd0, 0, 0, er);
    endtask
    task automatic req(input logic [3:0] op, input logic [1:0] cs,
                       input bit fa, input bit fl, input bit er);
        cyc(0, 0, 0, 8'h00, 1, op, cs, fa, fl, er);
    endtask

    typedef struct {
        logic [1:0] cs;
        bit         fa;
        bit         fl;
        bit         exp;
    } carry_case_t;

    carry_case_t carry_tab[6] = '{
        '{2'd1, 1'b1, 1'b0, 1'b1},
        '{2'd2, 1'b0, 1'b1, 1'b1},
        '{2'd3, 1'b0, 1'b0, 1'b1},
        '{2'd2, 1'b1, 1'b0, 1'b0},
        '{2'd1, 1'b0, 1'b1, 1'b0},
        '{2'd0, 1'b1, 1'b1, 1'b0}
    };

    initial begin
        bus.MainBus = '0; bus.Load_LHS = 0; bus.Load_RHS = 0;
        bus.Op_Valid = 0; bus.Op_Code = '0; bus.AC6_CS0 = 0; bus.AC7_CS1 = 0;
        bus.Flags_3_CarryA = 0; bus.Flags_4_CarryL = 0; bus.Exec_Ready = 0;

        // Reset state
        cyc(1, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0);
        #1;
        chk("rst_exec_valid", 32'(bus.Exec_Valid), 32'h0);
        chk("rst_exec_lhs", 32'(bus.Exec_LHS), 32'h0);
        chk("rst_exec_rhs", 32'(bus.Exec_RHS), 32'h0);
        chk("rst_exec_op", 32'(bus.Exec_Op), 32'h0);
        chk("rst_exec_carry", 32'(bus.Exec_CarryIn), 32'h0);
        chk("rst_op_ready", 32'(bus.Op_Ready), 32'h0);

        // Basic issue: 05 op 03
        ld_l(8'h05, 0);
        ld_r(8'h03, 0);
        req(4'h2, 2'd0, 0, 0, 0);
        #1;
        chk("basic_valid", 32'(bus.Exec_Valid), 32'h1);
        chk("basic_lhs", 32'(bus.Exec_LHS), 32'h05);
        chk("basic_rhs", 32'(bus.Exec_RHS), 32'h03);
        chk("basic_op", 32'(bus.Exec_Op), 32'h2);
        chk("basic_carry", 32'(bus.Exec_CarryIn), 32'h0);
        chk("basic_empty_after", 32'(bus.Op_Ready), 32'h0);

        // Request with only LHS present
        req(4'h0, 2'd0, 0, 0, 1);
        ld_l(8'h77, 1);
        for (int i = 0; i < 3; i++) begin
            req(4'h7, 2'd0, 0, 0, 1);
            #1 chk("lhs_only_not_ready", 32'(bus.Op_Ready), 32'h0);
        end
        cyc(0, 0, 1, 8'hFF, 1, 4'h7, 2'd0, 0, 0, 1);
        if (!c_bypass) req(4'h7, 2'd0, 0, 0, 1);
        #1;
        chk("late_rhs_valid", 32'(bus.Exec_Valid), 32'h1);
        chk("late_rhs_lhs", 32'(bus.Exec_LHS), 32'h77);
        chk("late_rhs_rhs", 32'(bus.Exec_RHS), 32'hFF);

        // Carry-select table
        foreach (carry_tab[k]) begin
            ld_b(8'h10 + 8'(k), 1);
            req(4'h4, carry_tab[k].cs, carry_tab[k].fa, carry_tab[k].fl, 1);
            #1 chk($sformatf("carry_case%0d", k), 32'(bus.Exec_CarryIn),
                   32'(carry_tab[k].exp));
        end

        // Execute stall then back-to-back replacement
        req(4'h0, 2'd0, 0, 0, 1);
        ld_b(8'h3C, 1);
        req(4'h9, 2'd0, 0, 0, 1);
        cyc(0, 1, 0, 8'h5A, 1, 4'hA, 2'd3, 0, 0, 0);
        #1 chk("stall_lhs_held", 32'(bus.Exec_LHS), 32'h3C);
        cyc(0, 0, 1, 8'h6B, 1, 4'hA, 2'd3, 0, 0, 0);
        #1 chk("stall_op_held", 32'(bus.Exec_Op), 32'h9);
        for (int i = 0; i < 2; i++) begin
            req(4'hA, 2'd3, 0, 0, 0);
            #1;
            chk("stall_valid_held", 32'(bus.Exec_Valid), 32'h1);
            chk("stall_rhs_held", 32'(bus.Exec_RHS), 32'h3C);
            chk("stall_not_ready", 32'(bus.Op_Ready), 32'h0);
        end
        req(4'hA, 2'd3, 0, 0, 1);
        #1;
        chk("replace_valid", 32'(bus.Exec_Valid), 32'h1);
        chk("replace_lhs", 32'(bus.Exec_LHS), 32'h5A);
        chk("replace_rhs", 32'(bus.Exec_RHS), 32'h6B);
        chk("replace_carry", 32'(bus.Exec_CarryIn), 32'h1);

        // Dual load, then overwrite of LHS
        ld_b(8'hA5, 1);
        req(4'h1, 2'd0, 0, 0, 1);
        #1;
        chk("dual_lhs", 32'(bus.Exec_LHS), 32'hA5);
        chk("dual_rhs", 32'(bus.Exec_RHS), 32'hA5);
        ld_b(8'hA5, 1);
        ld_l(8'h11, 1);
        req(4'h1, 2'd0, 0, 0, 1);
        #1;
        chk("overwrite_lhs", 32'(bus.Exec_LHS), 32'h11);
        chk("overwrite_rhs", 32'(bus.Exec_RHS), 32'hA5);

        // Reset mid-operation
        ld_l(8'h22, 1);
        ld_r(8'h33, 1);
        req(4'h5, 2'd0, 0, 0, 0);
        ld_l(8'h44, 0);
        cyc(1, 0, 0, 8'h00, 0, 4'h0, 2'd0, 0, 0, 0);
        #1;
        chk("midrst_valid", 32'(bus.Exec_Valid), 32'h0);
        chk("midrst_lhs", 32'(bus.Exec_LHS), 32'h0);
        chk("midrst_op", 32'(bus.Exec_Op), 32'h0);
        req(4'h5, 2'd0, 0, 0, 1);
        #1 chk("midrst_not_ready", 32'(bus.Op_Ready), 32'h0);
        ld_l(8'h66, 1);
        req(4'h5, 2'd0, 0, 0, 1);
        #1 chk("midrst_half_not_ready", 32'(bus.Op_Ready), 32'h0);
        ld_r(8'h77, 1);
        req(4'h5, 2'd0, 0, 0, 1);
        #1;
        chk("midrst_reload_valid", 32'(bus.Exec_Valid), 32'h1);
        chk("midrst_reload_lhs", 32'(bus.Exec_LHS), 32'h66);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 79) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0,
                8'($urandom),
                $urandom_range(0, 1) == 1,
                4'($urandom),
                2'($urandom),
                1'($urandom),
                1'($urandom),
                $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
